// File: rtl/pixel_bin_2x2_pkg.sv
// Shared definitions for the 2x2 pixel binning block: row-tracking states and the
// widths of the pair and block sums.
package pixel_bin_2x2_pkg;

    localparam int PIX_W   = 10;
    localparam int PAIR_W  = 11;
    localparam int TOTAL_W = 12;

    localparam logic [PIX_W-1:0] PIX_MAX = '1;

    typedef enum logic [1:0] {
        WAIT_EVEN = 2'd0,
        EVEN_ROW  = 2'd1,
        ODD_ROW   = 2'd2
    } rowState_t;

endpackage

// File: rtl/pixel_bin_2x2_line_buffer.sv
// Holds one even-row line of horizontal pair sums, one write port and one
// registered read port so it maps onto a block RAM.
module bin_line_buffer
    import pixel_bin_2x2_pkg::*;
#(
    parameter int DEPTH = 376,
    parameter int AW    = 9
) (
    input  logic              i_clk,
    input  logic              i_wrEn,
    input  logic [AW-1:0]     i_wrAddr,
    input  logic [PAIR_W-1:0] i_wrData,
    input  logic [AW-1:0]     i_rdAddr,
    output logic [PAIR_W-1:0] o_rdData
);

    logic [PAIR_W-1:0] r_mem [DEPTH];

    // No reset on purpose: a reset path would keep this from becoming block RAM.
    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
        o_rdData <= r_mem[i_rdAddr];
    end

endmodule

// File: rtl/pixel_bin_2x2.sv
// Averages each 2x2 block of a streaming sensor frame into one output pixel.
// Define PIXEL_BIN_ROUND_EN to round the average instead of truncating it.
module pixel_bin_2x2
    import pixel_bin_2x2_pkg::*;
#(
    parameter int H = 752,
    parameter int V = 480
) (
    input  logic                     PIXCLK,
    input  logic                     RST,
    input  logic                     PIXEL_VALID,
    input  logic [PIX_W-1:0]         DATA_IN,
    input  logic [$clog2(V)-1:0]     LINE_IN,
    input  logic [$clog2(H)-1:0]     COLUMN_IN,
    output logic                     BIN_VALID,
    output logic [PIX_W-1:0]         BIN_DATA,
    output logic [$clog2(V/2)-1:0]   BIN_LINE,
    output logic [$clog2(H/2)-1:0]   BIN_COLUMN,
    output logic                     FRAME_DONE
);

    localparam int H2  = H / 2;
    localparam int V2  = V / 2;
    localparam int LW  = $clog2(V);
    localparam int BLW = $clog2(V2);
    localparam int BCW = $clog2(H2);

    logic              w_inRange;
    logic              w_pixValid;
    logic              w_pairOk;
    logic              w_captureEven;
    logic              w_wrEn;
    logic              w_accEn;
    logic [BCW-1:0]    w_addr;
    logic [BLW-1:0]    w_binLine;
    logic [PAIR_W-1:0] w_pairSum;
    logic [PAIR_W-1:0] w_rdData;
    logic [TOTAL_W-1:0] w_total;
    logic [PIX_W-1:0]  w_binData;

    rowState_t         r_state;
    rowState_t         w_nextState;
    logic [LW-1:0]     r_evenLine;

    logic              r_holdValid;
    logic [PIX_W-1:0]  r_holdData;
    logic [BCW-1:0]    r_holdAddr;
    logic [LW-1:0]     r_holdLine;

    logic [H2-1:0]     r_written;

    logic              r_s1Valid;
    logic [PAIR_W-1:0] r_s1Sum;
    logic [BLW-1:0]    r_s1Line;
    logic [BCW-1:0]    r_s1Col;

    // Trailing column/line of an odd-sized sensor has no partner and is dropped here.
    assign w_inRange  = (int'(COLUMN_IN) < 2 * H2) && (int'(LINE_IN) < 2 * V2);
    assign w_pixValid = PIXEL_VALID && w_inRange;
    assign w_addr     = COLUMN_IN[BCW:1];
    assign w_binLine  = LINE_IN[BLW:1];

    assign w_pairOk  = w_pixValid && COLUMN_IN[0] && r_holdValid &&
                       (r_holdAddr == w_addr) && (r_holdLine == LINE_IN);
    assign w_pairSum = {1'b0, r_holdData} + {1'b0, DATA_IN};

    assign w_wrEn  = w_pairOk && (w_nextState == EVEN_ROW);
    assign w_accEn = w_pairOk && (w_nextState == ODD_ROW) && r_written[w_addr];

    always_ff @(posedge PIXCLK) begin
        if (RST) begin
            r_state    <= WAIT_EVEN;
            r_evenLine <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_captureEven) begin
                r_evenLine <= LINE_IN;
            end
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_captureEven = 1'b0;
        if (w_pixValid) begin
            case (r_state)
                WAIT_EVEN: begin
                    if (!LINE_IN[0]) begin
                        w_nextState   = EVEN_ROW;
                        w_captureEven = 1'b1;
                    end
                end
                EVEN_ROW: begin
                    if (LINE_IN == r_evenLine) begin
                        w_nextState = EVEN_ROW;
                    end else if (LINE_IN == r_evenLine + LW'(1)) begin
                        w_nextState = ODD_ROW;
                    end else if (!LINE_IN[0]) begin
                        w_nextState   = EVEN_ROW;
                        w_captureEven = 1'b1;
                    end else begin
                        w_nextState = WAIT_EVEN;
                    end
                end
                ODD_ROW: begin
                    if (LINE_IN == r_evenLine + LW'(1)) begin
                        w_nextState = ODD_ROW;
                    end else if (!LINE_IN[0]) begin
                        w_nextState   = EVEN_ROW;
                        w_captureEven = 1'b1;
                    end else begin
                        w_nextState = WAIT_EVEN;
                    end
                end
                default: w_nextState = WAIT_EVEN;
            endcase
        end
    end

    // Written bitmap is cleared whenever a new even line starts so stale buffer words never pair.
    always_ff @(posedge PIXCLK) begin
        if (RST) begin
            r_written <= '0;
        end else begin
            if (w_captureEven) begin
                r_written <= '0;
            end
            if (w_wrEn) begin
                r_written[w_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge PIXCLK) begin
        if (RST) begin
            r_holdValid <= 1'b0;
            r_s1Valid   <= 1'b0;
        end else begin
            if (w_pixValid) begin
                r_holdValid <= !COLUMN_IN[0];
            end
            r_s1Valid <= w_accEn;
        end
        if (w_pixValid && !COLUMN_IN[0]) begin
            r_holdData <= DATA_IN;
            r_holdAddr <= w_addr;
            r_holdLine <= LINE_IN;
        end
        r_s1Sum  <= w_pairSum;
        r_s1Line <= w_binLine;
        r_s1Col  <= w_addr;
    end

    bin_line_buffer #(
        .DEPTH (H2),
        .AW    (BCW)
    ) u_lineBuffer (
        .i_clk    (PIXCLK),
        .i_wrEn   (w_wrEn),
        .i_wrAddr (w_addr),
        .i_wrData (w_pairSum),
        .i_rdAddr (w_addr),
        .o_rdData (w_rdData)
    );

    assign w_total = TOTAL_W'(w_rdData) + TOTAL_W'(r_s1Sum);

`ifdef PIXEL_BIN_ROUND_EN
    logic [TOTAL_W:0]   w_rounded;
    logic [TOTAL_W-2:0] w_scaled;

    assign w_rounded = {1'b0, w_total} + (TOTAL_W+1)'(2);
    assign w_scaled  = (TOTAL_W-1)'(w_rounded >> 2);
    assign w_binData = (w_scaled > {1'b0, PIX_MAX}) ? PIX_MAX : w_scaled[PIX_W-1:0];
`else
    assign w_binData = PIX_W'(w_total >> 2);
`endif

    always_ff @(posedge PIXCLK) begin
        if (RST) begin
            BIN_VALID  <= 1'b0;
            FRAME_DONE <= 1'b0;
            BIN_DATA   <= '0;
            BIN_LINE   <= '0;
            BIN_COLUMN <= '0;
        end else begin
            BIN_VALID  <= r_s1Valid;
            FRAME_DONE <= r_s1Valid && (r_s1Line == BLW'(V2 - 1)) &&
                          (r_s1Col == BCW'(H2 - 1));
            if (r_s1Valid) begin
                BIN_DATA   <= w_binData;
                BIN_LINE   <= r_s1Line;
                BIN_COLUMN <= r_s1Col;
            end
        end
    end

endmodule

// File: doc/pixel_bin_2x2.md
PIXEL_BIN_2X2 -- requirements
Module: pixel_bin_2x2

Interface
REQ-001 Parameter H, default 752, sensor active columns per line.
REQ-002 Parameter V, default 480, sensor active lines per frame.
REQ-003 PIXCLK  in  1  pixel clock; all logic on rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 PIXEL_VALID  in  1  DATA_IN/LINE_IN/COLUMN_IN hold a valid pixel this cycle.
REQ-006 DATA_IN  in  10  pixel value.
REQ-007 LINE_IN  in  $clog2(V)  line index of pixel.
REQ-008 COLUMN_IN  in  $clog2(H)  column index of pixel.
REQ-009 BIN_VALID  out  1  BIN_DATA/BIN_LINE/BIN_COLUMN valid, one-cycle strobe per bin.
REQ-010 BIN_DATA  out  10  average of one 2x2 block.
REQ-011 BIN_LINE  out  $clog2(V/2)  output line = LINE_IN>>1 of the block.
REQ-012 BIN_COLUMN  out  $clog2(H/2)  output column = COLUMN_IN>>1 of the block.
REQ-013 FRAME_DONE  out  1  one-cycle pulse with the bin at (V/2-1, H/2-1).

Function
REQ-014 Block SHALL have no back-pressure; every input-valid cycle is accepted.
REQ-015 Pair stage: valid pixel with COLUMN_IN[0]=0 SHALL be held with its column; valid pixel with COLUMN_IN[0]=1 SHALL form an 11-bit pair sum only if held column = COLUMN_IN-1 and same LINE_IN, else dropped.
REQ-016 Row FSM states SHALL be WAIT_EVEN, EVEN_ROW, ODD_ROW.
REQ-017 WAIT_EVEN->EVEN_ROW on valid pixel with LINE_IN[0]=0; EVEN_ROW->ODD_ROW on valid pixel with LINE_IN = captured even line+1; ODD_ROW->EVEN_ROW on valid pixel with next even line; any other LINE_IN change SHALL go to WAIT_EVEN (or EVEN_ROW if the new line is even).
REQ-018 EVEN_ROW: pair sum SHALL be written to line buffer at address COLUMN_IN>>1.
REQ-019 ODD_ROW: pair sum SHALL be added to line buffer word at same address, 12-bit total.
REQ-020 BIN_DATA SHALL be total>>2 (truncation) unless ROUND_EN.
REQ-021 BIN_VALID SHALL assert exactly 2 PIXCLK cycles after the odd-row, odd-column pixel cycle.
REQ-022 Odd H: last column SHALL be ignored; odd V: last line SHALL be ignored.
REQ-023 Odd-row pair whose even-row address was not written in the current even row SHALL produce no output (per-address written bitmap or equivalent).
REQ-024 Unpaired even-column pixel at line end SHALL be discarded without output.

Reset
REQ-025 On RST: BIN_VALID=0, FRAME_DONE=0, BIN_DATA=0, BIN_LINE=0, BIN_COLUMN=0, FSM=WAIT_EVEN, pair holder and pipeline valids cleared.
REQ-026 Line buffer contents SHALL NOT be reset; written bitmap SHALL be cleared.
REQ-027 RST mid-frame SHALL suppress all in-flight bins; output resumes from next complete even/odd line pair.

Configuration
REQ-028 Macro PIXEL_BIN_ROUND_EN defined: BIN_DATA = min((total+2)>>2, 1023); undefined: BIN_DATA = total>>2 with no rounding logic.

Structure
REQ-029 Shared package SHALL hold row-FSM state typedef and sum widths (PAIR_W=11, TOTAL_W=12).
REQ-030 Line buffer SHALL be sub-module bin_line_buffer: H/2 x 11-bit, one write and one registered read port, inferable as block RAM.

Verification
REQ-031 Flat frame, all pixels 100 -> H/2*V/2 bins, each BIN_DATA=100, FRAME_DONE once at (239,375).
REQ-032 Block pixels 0,1,2,3 at (0,0),(0,1),(1,0),(1,1) -> BIN_DATA=1 truncated, 2 with PIXEL_BIN_ROUND_EN; BIN_VALID 2 cycles after (1,1).
REQ-033 All pixels 1023 with PIXEL_BIN_ROUND_EN -> BIN_DATA=1023, no wrap.
REQ-034 Frame starting at line 1 (odd) -> no bins until lines 2/3 complete; first BIN_LINE=1.
REQ-035 RST asserted during line 3 column 100 -> no BIN_VALID for that line; next frame produces full bin count.
REQ-036 PIXEL_VALID gap dropping column 10 of line 4 -> no bin at (2,5); neighbours (2,4),(2,6) correct.
